fft_frame_feeder: RTL and testbench

- Collects audio codec samples into a circular sample FIFO and emits fixed-length frames to the FFT core sink over an Avalon-ST valid/ready interface.
- Drives sop/eop framing, so the downstream magnitude/peak stage sees one packet per frame.
- Sits between the audio codec receiver (sample clock-enable pulses on clk) and the FFT core.
- Optional keep-1-of-N decimation sets the analysed bandwidth.

---
 rtl/fft_frame_feeder.sv | 147 ++++++++++++++
 tb/tb_fft_frame_feeder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_feeder.sv
// Buffers decimated codec samples in a circular FIFO and streams fixed-length
// sop/eop-framed packets to the FFT core over an Avalon-ST valid/ready sink.
module fft_frame_feeder #(
  parameter int FFT_LEN    = 128,
  parameter int DEPTH      = 256,
  parameter int DECIM      = 1,
  parameter int GAP_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_sample_valid,
  input  logic signed [15:0]        i_sample,
  input  logic                      i_sink_ready,
  output logic                      o_sink_valid,
  output logic                      o_sink_sop,
  output logic                      o_sink_eop,
  output logic signed [17:0]        o_sink_real,
  output logic [17:0]               o_sink_imag,
  output logic [1:0]                o_sink_error,
  output logic                      o_overflow,
  output logic [15:0]               o_frame_cnt,
  output logic [$clog2(DEPTH):0]    o_fill
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int WW = $clog2(FFT_LEN);
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [FW-1:0] FULL   = FW'(DEPTH);
  localparam logic [FW-1:0] FRAME  = FW'(FFT_LEN);
  localparam logic [WW-1:0] LAST_W = WW'(FFT_LEN - 1);
  localparam logic [WW-1:0] PRE_W  = WW'(FFT_LEN - 2);
  localparam logic [DW-1:0] LAST_D = DW'((DECIM > 1) ? DECIM - 1 : 0);
  localparam logic [GW-1:0] LAST_G = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  function automatic logic signed [17:0] sext18(input logic signed [15:0] s);
    return {{2{s[15]}}, s};
  endfunction

  state_t                  state, state_n;
  logic signed [15:0]      mem [DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr, rd_nxt;
  logic [FW-1:0]           fill;
  logic [DW-1:0]           dcnt;
  logic [WW-1:0]           wcnt;
  logic [GW-1:0]           gcnt;
  logic                    kept, push, xfer, last_w;
  logic                    arm_p0;

  assign kept   = i_sample_valid && (dcnt == '0);
  assign push   = kept && (fill < FULL);
  assign xfer   = o_sink_valid && i_sink_ready;
  assign last_w = (wcnt == LAST_W);
  assign rd_nxt = rd_ptr + AW'(1);

  assign o_sink_imag  = '0;
  assign o_sink_error = '0;
  assign o_fill       = fill;

  // ---- input side: decimation, FIFO write, occupancy ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dcnt       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill       <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (i_sample_valid) dcnt <= (dcnt == LAST_D) ? '0 : dcnt + DW'(1);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (xfer) rd_ptr <= rd_nxt;
      fill <= fill + FW'(push) - FW'(xfer);
      // Full is judged on the registered fill, so a same-cycle pop does not save the sample.
      if (kept && !push) o_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_sample;
  end

  // ---- p0: registered frame-ready threshold, only armed while idle ----
  always_ff @(posedge clk) begin
    if (!rst_n) arm_p0 <= 1'b0;
    else        arm_p0 <= (state == IDLE) && (fill >= FRAME);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (arm_p0) state_n = SEND;
      SEND:    if (xfer && last_w) state_n = (GAP_CYCLES > 0) ? GAP : IDLE;
      GAP:     if (gcnt == LAST_G) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // ---- sink side: registered frame word, framing flags and counters ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_sink_valid <= 1'b0;
      o_sink_sop   <= 1'b0;
      o_sink_eop   <= 1'b0;
      o_sink_real  <= '0;
      o_frame_cnt  <= '0;
      wcnt         <= '0;
      gcnt         <= '0;
    end else begin
      unique case (state)
        IDLE: if (arm_p0) begin
          o_sink_valid <= 1'b1;
          o_sink_sop   <= 1'b1;
          o_sink_eop   <= 1'b0;
          o_sink_real  <= sext18(mem[rd_ptr]);
          wcnt         <= '0;
        end
        SEND: if (xfer) begin
          if (last_w) begin
            o_sink_valid <= 1'b0;
            o_sink_sop   <= 1'b0;
            o_sink_eop   <= 1'b0;
            o_frame_cnt  <= o_frame_cnt + 16'd1;
            gcnt         <= '0;
          end else begin
            // Prefetch the word behind the one being popped so there is no bubble.
            wcnt         <= wcnt + WW'(1);
            o_sink_sop   <= 1'b0;
            o_sink_eop   <= (wcnt == PRE_W);
            o_sink_real  <= sext18(mem[rd_nxt]);
          end
        end
        GAP:     gcnt <= gcnt + GW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Scoreboard bench for fft_frame_feeder: stimulus queues expected frame words,
// negedge monitors pop and compare whatever the sinks present.
module tb_fft_frame_feeder;

  typedef struct packed {
    logic [17:0] re;
    logic        sop;
    logic        eop;
  } exp_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, s_valid, s_ready, d_valid, d_ready;
  logic [15:0] sample;

  logic        v_o, sop_o, eop_o, ovf_o;
  logic [17:0] re_o, im_o;
  logic [1:0]  err_o;
  logic [15:0] fc_o;
  logic [8:0]  fill_o;

  logic        d_v_o, d_sop_o, d_eop_o, d_ovf_o;
  logic [17:0] d_re_o, d_im_o;
  logic [1:0]  d_err_o;
  logic [15:0] d_fc_o;
  logic [8:0]  d_fill_o;

  fft_frame_feeder dut (
    .clk(clk), .rst_n(rst_n), .i_sample_valid(s_valid), .i_sample(sample),
    .i_sink_ready(s_ready), .o_sink_valid(v_o), .o_sink_sop(sop_o), .o_sink_eop(eop_o),
    .o_sink_real(re_o), .o_sink_imag(im_o), .o_sink_error(err_o),
    .o_overflow(ovf_o), .o_frame_cnt(fc_o), .o_fill(fill_o)
  );

  fft_frame_feeder #(.DECIM(4)) dut_d (
    .clk(clk), .rst_n(rst_n), .i_sample_valid(d_valid), .i_sample(sample),
    .i_sink_ready(d_ready), .o_sink_valid(d_v_o), .o_sink_sop(d_sop_o), .o_sink_eop(d_eop_o),
    .o_sink_real(d_re_o), .o_sink_imag(d_im_o), .o_sink_error(d_err_o),
    .o_overflow(d_ovf_o), .o_frame_cnt(d_fc_o), .o_fill(d_fill_o)
  );

  int   checks = 0, failures = 0;
  int   mfill = 0, kcnt = 0, kd = 0, wif = 0, efc = 0;
  exp_t exp_q[$], exp_dq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] v, input int k);
    logic signed [15:0] sv;
    logic signed [17:0] ext;
    exp_t e;
    sv    = v;
    ext   = sv;
    e.re  = ext;
    e.sop = (k % 128 == 0);
    e.eop = (k % 128 == 127);
    return e;
  endfunction

  task automatic push(input logic [15:0] v);
    @(posedge clk); #1;
    s_valid = 1'b1;
    sample  = v;
    if (mfill < 256) begin
      exp_q.push_back(mk(v, kcnt));
      kcnt++;
      mfill++;
    end
  endtask

  task automatic idle_in();
    @(posedge clk); #1;
    s_valid = 1'b0;
    d_valid = 1'b0;
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk); #1;
    s_ready = r;
  endtask

  task automatic wait_fc(input logic [15:0] tgt, input int budget);
    int n = 0;
    while (fc_o !== tgt && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("frame_cnt", 32'(fc_o), 32'(tgt));
  endtask

  // Main sink monitor: compares the presented word while stalled and on transfer.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && v_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("extra_word", 32'd1, 32'd0);
      end else begin
        e = exp_q[0];
        chk(s_ready ? "xfer_real" : "hold_real", 32'(re_o), 32'(e.re));
        chk(s_ready ? "xfer_sop" : "hold_sop", 32'(sop_o), 32'(e.sop));
        chk(s_ready ? "xfer_eop" : "hold_eop", 32'(eop_o), 32'(e.eop));
        if (s_ready) begin
          e = exp_q.pop_front();
          chk("imag_err", {12'd0, im_o, err_o}, 32'd0);
          mfill--;
          wif = sop_o ? 1 : wif + 1;
        end
      end
    end
  end

  // Decimating instance monitor.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && d_v_o === 1'b1 && d_ready) begin
      if (exp_dq.size() == 0) begin
        chk("d_extra_word", 32'd1, 32'd0);
      end else begin
        e = exp_dq.pop_front();
        chk("d_real", 32'(d_re_o), 32'(e.re));
        chk("d_sop", 32'(d_sop_o), 32'(e.sop));
        chk("d_eop", 32'(d_eop_o), 32'(e.eop));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int zeros;
    int n;
    bit found;
    rst_n = 1'b0; s_valid = 1'b0; d_valid = 1'b0;
    s_ready = 1'b1; d_ready = 1'b1; sample = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(v_o), 32'd0);
    chk("rst_sop_eop", {30'd0, sop_o, eop_o}, 32'd0);
    chk("rst_real", 32'(re_o), 32'd0);
    chk("rst_fill", 32'(fill_o), 32'd0);
    chk("rst_frame_cnt", 32'(fc_o), 32'd0);
    chk("rst_overflow", 32'(ovf_o), 32'd0);
    chk("rst_imag_err", {12'd0, im_o, err_o}, 32'd0);
    chk("rst_d_fill", 32'(d_fill_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic frame: value n at sample n
    for (int i = 0; i < 128; i++) push(16'(i));
    idle_in();
    efc = 1;
    wait_fc(16'(efc), 400);
    repeat (2) @(negedge clk);
    chk("basic_fill", 32'(fill_o), 32'd0);
    chk("basic_q_empty", 32'(exp_q.size()), 32'd0);

    // Sign extension at the 16-bit extremes
    push(16'h8000);
    push(16'h7FFF);
    for (int i = 2; i < 128; i++) push(16'(i * 3));
    idle_in();
    efc = 2;
    wait_fc(16'(efc), 400);

    // Backpressure: ready pattern 1,0,0 repeating
    fork
      begin
        for (int i = 0; i < 128; i++) push(16'(500 + i));
        idle_in();
      end
      begin
        for (int j = 0; j < 600; j++) set_ready(j % 3 == 0);
      end
    join
    set_ready(1'b1);
    efc = 3;
    wait_fc(16'(efc), 400);
    repeat (2) @(negedge clk);
    chk("bp_q_empty", 32'(exp_q.size()), 32'd0);

    // Overflow: ready held low, 300 samples
    set_ready(1'b0);
    for (int i = 0; i < 257; i++) push(16'(i));
    idle_in();
    @(negedge clk);
    chk("ovf_fill_full", 32'(fill_o), 32'd256);
    chk("ovf_set", 32'(ovf_o), 32'd1);
    for (int i = 257; i < 300; i++) push(16'(i));
    idle_in();
    set_ready(1'b1);
    efc = 5;
    wait_fc(16'(efc), 800);
    repeat (2) @(negedge clk);
    chk("ovf_sticky", 32'(ovf_o), 32'd1);
    chk("ovf_fill_drain", 32'(fill_o), 32'd0);
    chk("ovf_q_empty", 32'(exp_q.size()), 32'd0);

    // Gap: two frames buffered, count idle cycles between eop and next sop
    set_ready(1'b0);
    for (int i = 0; i < 256; i++) push(16'(1000 + i));
    idle_in();
    set_ready(1'b1);
    found = 1'b0;
    n = 0;
    while (!found && n < 400) begin
      @(negedge clk);
      n++;
      if (v_o && s_ready && eop_o) found = 1'b1;
    end
    chk("gap_eop_seen", 32'(found), 32'd1);
    zeros = 0;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (v_o) break;
      zeros++;
    end
    chk("gap_idle_cycles", 32'(zeros), 32'd6);
    chk("gap_next_sop", 32'(sop_o), 32'd1);
    efc = 7;
    wait_fc(16'(efc), 400);

    // Decimation by 4 on the second instance
    for (int i = 0; i < 512; i++) begin
      @(posedge clk); #1;
      d_valid = 1'b1;
      sample  = 16'(i);
      if (i % 4 == 0) begin
        exp_dq.push_back(mk(16'(i), kd));
        kd++;
      end
    end
    idle_in();
    n = 0;
    while (d_fc_o !== 16'd1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("d_frame_cnt", 32'(d_fc_o), 32'd1);
    repeat (2) @(negedge clk);
    chk("d_fill", 32'(d_fill_o), 32'd0);
    chk("d_q_empty", 32'(exp_dq.size()), 32'd0);

    // Reset at word 60 of a frame
    for (int i = 0; i < 128; i++) push(16'(2000 + i));
    idle_in();
    found = 1'b0;
    n = 0;
    while (!found && n < 600) begin
      @(posedge clk); #1;
      n++;
      if (wif == 60 && v_o) found = 1'b1;
    end
    chk("mid_reached_60", 32'(found), 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    mfill = 0;
    kcnt  = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(v_o), 32'd0);
    chk("mid_rst_fill", 32'(fill_o), 32'd0);
    chk("mid_rst_frame_cnt", 32'(fc_o), 32'd0);
    chk("mid_rst_overflow", 32'(ovf_o), 32'd0);
    for (int i = 0; i < 128; i++) push(16'(3000 + i));
    idle_in();
    efc = 1;
    wait_fc(16'(efc), 400);
    repeat (2) @(negedge clk);
    chk("end_fill", 32'(fill_o), 32'd0);
    chk("end_q_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
